// File: rtl/alu_issue_controller.sv
// alu_issue_controller: sequences one ARM data-processing instruction at a time
// through the combinational ALU. It evaluates the condition field against the
// CPSR, captures the ALU result/flags, updates the CPSR and hands the result to
// register-file writeback over a valid/ready handshake.
// Optional build macro: ALU_CTRL_PERF_EN adds exec_count/skip_count counters.
module alu_issue_controller #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic [4:0]        in_op,
    input  logic              in_s,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [4:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        cpsr_flags,
    output logic              retire,
    output logic              retire_skipped
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [15:0]       exec_count,
    output logic [15:0]       skip_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        WB      = 2'd3
    } state_t;

    state_t              state_r;
    logic                issue_ok_r;   // condition passed and op legal
    logic                s_r;
    logic                cmp_r;        // TST/TEQ/CMP/CMN: flags only, no writeback
    logic [REG_AW-1:0]   rd_r;

    // ARM condition evaluation; flags are {V,N,C,Z}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic v_s;
        logic n_s;
        logic c_s;
        logic z_s;
        logic pass_s;
        v_s = flags[3];
        n_s = flags[2];
        c_s = flags[1];
        z_s = flags[0];
        case (cond)
            4'b0000: pass_s = z_s;
            4'b0001: pass_s = !z_s;
            4'b0010: pass_s = c_s;
            4'b0011: pass_s = !c_s;
            4'b0100: pass_s = n_s;
            4'b0101: pass_s = !n_s;
            4'b0110: pass_s = v_s;
            4'b0111: pass_s = !v_s;
            4'b1000: pass_s = c_s && !z_s;
            4'b1001: pass_s = !c_s || z_s;
            4'b1010: pass_s = (n_s == v_s);
            4'b1011: pass_s = (n_s != v_s);
            4'b1100: pass_s = !z_s && (n_s == v_s);
            4'b1101: pass_s = z_s || (n_s != v_s);
            4'b1110: pass_s = 1'b1;
            4'b1111: pass_s = 1'b0;
            default: pass_s = 1'b0;
        endcase
        return pass_s;
    endfunction

    // Legal codes are 00000-00100 and 01000-01111.
    function automatic logic op_legal(input logic [4:0] op);
        return (op[4] == 1'b0) && ((op[3] == 1'b1) || (op[2:0] <= 3'd4));
    endfunction

    // Codes 01000-01011 only update flags.
    function automatic logic op_is_compare(input logic [4:0] op);
        return (op[4:2] == 3'b010);
    endfunction

    // Issue sequencer: state, ALU drive, CPSR, writeback and retire outputs.
    // The CPSR cannot change between accept and ISSUE, so the condition is
    // resolved at accept; that lets alu_op read 0 throughout a skipped ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            issue_ok_r     <= 1'b0;
            s_r            <= 1'b0;
            cmp_r          <= 1'b0;
            rd_r           <= {REG_AW{1'b0}};
            in_ready       <= 1'b1;
            alu_data1      <= {DATA_W{1'b0}};
            alu_data2      <= {DATA_W{1'b0}};
            alu_op         <= 5'd0;
            wb_valid       <= 1'b0;
            wb_rd          <= {REG_AW{1'b0}};
            wb_data        <= {DATA_W{1'b0}};
            cpsr_flags     <= 4'd0;
            retire         <= 1'b0;
            retire_skipped <= 1'b0;
`ifdef ALU_CTRL_PERF_EN
            exec_count     <= 16'd0;
            skip_count     <= 16'd0;
`endif
        end else begin
            retire         <= 1'b0;
            retire_skipped <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        in_ready   <= 1'b0;
                        rd_r       <= in_rd;
                        s_r        <= in_s;
                        cmp_r      <= op_is_compare(in_op);
                        issue_ok_r <= op_legal(in_op) && cond_pass(in_cond, cpsr_flags);
                        alu_op     <= (op_legal(in_op) && cond_pass(in_cond, cpsr_flags)) ? in_op : 5'd0;
                        alu_data1  <= in_data1;
                        alu_data2  <= in_data2;
                        state_r    <= ISSUE;
                    end else begin
                        in_ready   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!issue_ok_r) begin
                        retire         <= 1'b1;
                        retire_skipped <= 1'b1;
                        alu_op         <= 5'd0;
                        alu_data1      <= {DATA_W{1'b0}};
                        alu_data2      <= {DATA_W{1'b0}};
                        in_ready       <= 1'b1;
                        state_r        <= IDLE;
`ifdef ALU_CTRL_PERF_EN
                        skip_count     <= skip_count + 16'd1;
`endif
                    end else begin
                        state_r        <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cmp_r || s_r) begin
                        cpsr_flags <= alu_flags;
                    end else begin
                        cpsr_flags <= cpsr_flags;
                    end
                    alu_op    <= 5'd0;
                    alu_data1 <= {DATA_W{1'b0}};
                    alu_data2 <= {DATA_W{1'b0}};
                    if (cmp_r) begin
                        retire     <= 1'b1;
                        in_ready   <= 1'b1;
                        state_r    <= IDLE;
`ifdef ALU_CTRL_PERF_EN
                        exec_count <= exec_count + 16'd1;
`endif
                    end else begin
                        wb_valid   <= 1'b1;
                        wb_data    <= alu_result;
                        wb_rd      <= rd_r;
                        state_r    <= WB;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        retire     <= 1'b1;
                        wb_valid   <= 1'b0;
                        in_ready   <= 1'b1;
                        state_r    <= IDLE;
`ifdef ALU_CTRL_PERF_EN
                        exec_count <= exec_count + 16'd1;
`endif
                    end else begin
                        wb_valid   <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    in_ready <= 1'b1;
                    wb_valid <= 1'b0;
                    alu_op   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_controller.sv
// Self-checking bench for alu_issue_controller. Expected writebacks and retire
// outcomes are queued when an instruction is driven and checked by a monitor
// when the DUT produces them. Build with ALU_CTRL_PERF_EN to cover counters.
module tb_alu_issue_controller;

    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_CMP = 5'b01010;
    localparam logic [4:0] OP_ORR = 5'b01100;
    localparam logic [4:0] OP_MOV = 5'b01101;
    localparam logic [3:0] C_EQ   = 4'b0000;
    localparam logic [3:0] C_AL   = 4'b1110;
    localparam logic [3:0] C_NV   = 4'b1111;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_cond = 4'd0;
    logic [4:0]  in_op = 5'd0;
    logic        in_s = 1'b0;
    logic [3:0]  in_rd = 4'd0;
    logic [31:0] in_data1 = 32'd0;
    logic [31:0] in_data2 = 32'd0;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [4:0]  alu_op;
    logic [31:0] alu_result = 32'd0;
    logic [3:0]  alu_flags = 4'd0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  cpsr_flags;
    logic        retire;
    logic        retire_skipped;
`ifdef ALU_CTRL_PERF_EN
    logic [15:0] exec_count;
    logic [15:0] skip_count;
`endif

    int   n_checks = 0;
    int   n_fail = 0;
    int   exec_m = 0;
    int   skip_m = 0;
    logic [3:0] model_cpsr = 4'd0;
    wb_t  wb_q[$];
    logic ret_q[$];

    alu_issue_controller #(.DATA_W(32), .REG_AW(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_op(in_op), .in_s(in_s), .in_rd(in_rd),
        .in_data1(in_data1), .in_data2(in_data2),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .cpsr_flags(cpsr_flags), .retire(retire), .retire_skipped(retire_skipped)
`ifdef ALU_CTRL_PERF_EN
        , .exec_count(exec_count), .skip_count(skip_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference condition table, flags {V,N,C,Z}.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic v, n, cy, z;
        v = f[3]; n = f[2]; cy = f[1]; z = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy & !z;
            4'd9:  return !cy | z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z & (n == v);
            4'd13: return z | (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: retire and writeback events are checked against the scoreboard.
    always @(negedge clk) begin
        wb_t e;
        logic es;
        if (!reset && wb_valid === 1'b1 && wb_ready === 1'b1) begin
            n_checks++;
            if (wb_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no writeback", wb_rd, wb_data);
            end else begin
                e = wb_q.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    n_fail++;
                    $display("FAIL wb_data: got rd=%0d data=%h, expected rd=%0d data=%h", wb_rd, wb_data, e.rd, e.data);
                end
            end
        end
        if (!reset && retire === 1'b1) begin
            n_checks++;
            if (ret_q.size() == 0) begin
                n_fail++;
                $display("FAIL retire_unexpected: got retire skipped=%b, expected no retire", retire_skipped);
            end else begin
                es = ret_q.pop_front();
                if (retire_skipped !== es) begin
                    n_fail++;
                    $display("FAIL retire_skipped: got %b expected %b", retire_skipped, es);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        wb_q.delete(); ret_q.delete();
        model_cpsr = 4'd0; exec_m = 0; skip_m = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one instruction, supply ALU response, track expected outcome and latency.
    task automatic run_instr(input string name, input logic [3:0] cond, input logic [4:0] op,
                             input logic s, input logic [3:0] rd, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] res, input logic [3:0] fl,
                             input int stall);
        logic legal, pass, cmp;
        int cyc, exp_cyc, vcnt, guard;
        wb_t w;
        legal = (op <= 5'd4) || (op >= 5'd8 && op <= 5'd15);
        pass  = legal && cond_model(cond, model_cpsr);
        cmp   = (op >= 5'd8 && op <= 5'd11);
        exp_cyc = !pass ? 1 : (cmp ? 2 : 3 + stall);
        @(negedge clk);
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready_wait: got %b expected 1", name, in_ready);
        end
        ret_q.push_back(!pass);
        if (pass && !cmp) begin
            w.rd = rd; w.data = res;
            wb_q.push_back(w);
        end
        if (pass) exec_m++; else skip_m++;
        in_valid = 1'b1; in_cond = cond; in_op = op; in_s = s; in_rd = rd;
        in_data1 = d1; in_data2 = d2; alu_result = res; alu_flags = fl;
        wb_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (alu_op !== (pass ? op : 5'd0) || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s issue: got alu_op=%b in_ready=%b expected alu_op=%b in_ready=0",
                     name, alu_op, in_ready, pass ? op : 5'd0);
        end
        if (pass) begin
            n_checks++;
            if (alu_data1 !== d1 || alu_data2 !== d2) begin
                n_fail++;
                $display("FAIL %s operands: got %h/%h expected %h/%h", name, alu_data1, alu_data2, d1, d2);
            end
        end
        cyc = 0; vcnt = 0;
        while (in_ready !== 1'b1 && cyc < 60) begin
            if (wb_valid === 1'b1) begin
                n_checks++;
                if (wb_data !== res || wb_rd !== rd) begin
                    n_fail++;
                    $display("FAIL %s wb_hold: got rd=%0d data=%h expected rd=%0d data=%h", name, wb_rd, wb_data, rd, res);
                end
                if (vcnt >= stall) wb_ready = 1'b1;
                vcnt++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc !== exp_cyc) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, cyc, exp_cyc);
        end
        wb_ready = 1'b0;
        if (pass && (cmp || s)) model_cpsr = fl;
        n_checks++;
        if (cpsr_flags !== model_cpsr) begin
            n_fail++;
            $display("FAIL %s cpsr: got %b expected %b", name, cpsr_flags, model_cpsr);
        end
        n_checks++;
        if (alu_op !== 5'd0 || alu_data1 !== 32'd0 || alu_data2 !== 32'd0 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_outputs: got alu_op=%b d1=%h d2=%h wb_valid=%b expected all 0",
                     name, alu_op, alu_data1, alu_data2, wb_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || retire !== 1'b0 || retire_skipped !== 1'b0 ||
            cpsr_flags !== 4'd0 || alu_op !== 5'd0 || alu_data1 !== 32'd0 || wb_data !== 32'd0 || wb_rd !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got in_ready=%b wb_valid=%b retire=%b cpsr=%b alu_op=%b expected 1/0/0/0000/0",
                     in_ready, wb_valid, retire, cpsr_flags, alu_op);
        end
    endtask

    task automatic test_add();
        run_instr("add", C_AL, OP_ADD, 1'b1, 4'd5, 32'd3, 32'd7, 32'd10, 4'b0000, 0);
    endtask

    task automatic test_cmp_addeq();
        run_instr("cmp_eq", C_AL, OP_CMP, 1'b0, 4'd0, 32'd7, 32'd7, 32'd0, 4'b0001, 0);
        run_instr("addeq", C_EQ, OP_ADD, 1'b0, 4'd2, 32'd1, 32'd2, 32'd3, 4'b0000, 0);
    endtask

    task automatic test_moveq_skip();
        run_instr("cmp_ne", C_AL, OP_CMP, 1'b0, 4'd0, 32'd7, 32'd8, 32'd0, 4'b0100, 0);
        run_instr("moveq", C_EQ, OP_MOV, 1'b1, 4'd3, 32'd0, 32'd9, 32'd9, 4'b0001, 0);
    endtask

    task automatic test_orr_stall();
        run_instr("orr_stall", C_AL, OP_ORR, 1'b0, 4'd11, 32'hF0, 32'h0F, 32'hFF, 4'b0000, 5);
    endtask

    task automatic test_illegal();
        run_instr("illegal_10000", C_AL, 5'b10000, 1'b1, 4'd4, 32'd1, 32'd1, 32'd2, 4'b1111, 0);
        run_instr("illegal_00101", C_AL, 5'b00101, 1'b1, 4'd4, 32'd1, 32'd1, 32'd2, 4'b1111, 0);
        run_instr("never", C_NV, OP_ADD, 1'b1, 4'd4, 32'd1, 32'd1, 32'd2, 4'b1111, 0);
    endtask

    task automatic test_reset_in_wb();
        int guard;
        @(negedge clk);
        while (in_ready !== 1'b1) @(negedge clk);
        in_valid = 1'b1; in_cond = C_AL; in_op = OP_ORR; in_s = 1'b1; in_rd = 4'd9;
        in_data1 = 32'd5; in_data2 = 32'd50; alu_result = 32'd55; alu_flags = 4'b0100; wb_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (wb_valid !== 1'b1 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (wb_valid !== 1'b1 || cpsr_flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL rst_wb_pre: got wb_valid=%b cpsr=%b expected 1/0100", wb_valid, cpsr_flags);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1 || cpsr_flags !== 4'd0 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wb_post: got wb_valid=%b in_ready=%b cpsr=%b retire=%b expected 0/1/0000/0",
                     wb_valid, in_ready, cpsr_flags, retire);
        end
        @(negedge clk);
        reset = 1'b0;
        model_cpsr = 4'd0; exec_m = 0; skip_m = 0;
        repeat (3) @(posedge clk);
    endtask

`ifdef ALU_CTRL_PERF_EN
    task automatic test_perf();
        do_reset();
        run_instr("perf_add", C_AL, OP_ADD, 1'b0, 4'd1, 32'd1, 32'd1, 32'd2, 4'b0000, 0);
        run_instr("perf_cmp", C_AL, OP_CMP, 1'b0, 4'd0, 32'd1, 32'd1, 32'd0, 4'b0001, 0);
        run_instr("perf_skip1", 4'b0001, OP_MOV, 1'b0, 4'd2, 32'd0, 32'd4, 32'd4, 4'b0000, 0);
        run_instr("perf_mov", C_EQ, OP_MOV, 1'b0, 4'd2, 32'd0, 32'd4, 32'd4, 4'b0000, 0);
        run_instr("perf_skip2", C_AL, 5'b11111, 1'b0, 4'd2, 32'd0, 32'd4, 32'd4, 4'b0000, 0);
        @(negedge clk);
        n_checks++;
        if (exec_count !== 16'd3 || skip_count !== 16'd2) begin
            n_fail++;
            $display("FAIL perf_counts: got exec=%0d skip=%0d expected 3/2", exec_count, skip_count);
        end
        do_reset();
        n_checks++;
        if (exec_count !== 16'd0 || skip_count !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got exec=%0d skip=%0d expected 0/0", exec_count, skip_count);
        end
    endtask
`endif

    task automatic test_cond_sweep();
        logic [3:0] fl_tab [6];
        fl_tab[0] = 4'b0001; fl_tab[1] = 4'b0010; fl_tab[2] = 4'b0100;
        fl_tab[3] = 4'b1000; fl_tab[4] = 4'b0110; fl_tab[5] = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            run_instr("sweep_cmp", C_AL, OP_CMP, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, fl_tab[i], 0);
            for (int c = 0; c < 16; c++) begin
                run_instr("sweep_mov", 4'(c), OP_MOV, 1'b0, 4'(c), 32'd0, 32'(c),
                          32'(c * 3 + i), 4'b1111, 0);
            end
            run_instr("sweep_adds", C_AL, OP_ADD, 1'b1, 4'd7, 32'd2, 32'(i), 32'(i + 2), 4'(i + 3), 0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp_addeq();
        test_moveq_skip();
        test_orr_stall();
        test_illegal();
`ifdef ALU_CTRL_PERF_EN
        test_perf();
`endif
        test_reset_in_wb();
        test_cond_sweep();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (wb_q.size() != 0 || ret_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d writebacks and %0d retires outstanding, expected 0/0", wb_q.size(), ret_q.size());
        end
`ifdef ALU_CTRL_PERF_EN
        n_checks++;
        if (exec_count !== 16'(exec_m) || skip_count !== 16'(skip_m)) begin
            n_fail++;
            $display("FAIL perf_final: got exec=%0d skip=%0d expected %0d/%0d", exec_count, skip_count, exec_m, skip_m);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
